// File: rtl/tx_packet_builder_pkg.sv
// Shared types and helpers for the TX packet builder: packet type codes, payload
// lengths and the per-type payload field ordering.
package tx_packet_builder_pkg;

  localparam int unsigned WORD_WIDTH = 16;
  localparam int unsigned SelIdxW    = 3;

  typedef enum logic [2:0] {
    PKT_HEARTBEAT    = 3'd1,
    PKT_CH_ANNOUNCE  = 3'd2,
    PKT_DATA         = 3'd3,
    PKT_CH_JOIN      = 3'd4,
    PKT_ROUTE_UPDATE = 3'd5
  } pktTypeE;

  typedef enum logic [2:0] {
    FldNone,
    FldSourceID,
    FldEnergyLeft,
    FldQValue,
    FldSourceHops,
    FldDestinationID,
    FldChosenCH,
    FldHopsFromCH
  } fieldSelE;

  function automatic logic isValidType(input logic [2:0] pktType);
    return (pktType >= 3'd1) && (pktType <= 3'd5);
  endfunction

  function automatic logic [3:0] pktLen(input logic [2:0] pktType);
    logic [3:0] len;
    len = 4'd0;
    case (pktType)
      PKT_HEARTBEAT:    len = 4'd4;
      PKT_CH_ANNOUNCE:  len = 4'd5;
      PKT_DATA:         len = 4'd5;
      PKT_CH_JOIN:      len = 4'd4;
      PKT_ROUTE_UPDATE: len = 4'd7;
      default:          len = 4'd0;
    endcase
    return len;
  endfunction

  function automatic fieldSelE fieldSel(input logic [2:0] pktType,
                                        input logic [SelIdxW-1:0] index);
    fieldSelE sel;
    sel = FldNone;
    case (pktType)
      PKT_HEARTBEAT, PKT_CH_ANNOUNCE: begin
        case (index)
          3'd0:    sel = FldSourceID;
          3'd1:    sel = FldSourceHops;
          3'd2:    sel = FldQValue;
          3'd3:    sel = FldEnergyLeft;
          // Only CH_ANNOUNCE reaches index 4; HEARTBEAT stops at 3.
          3'd4:    sel = FldChosenCH;
          default: sel = FldNone;
        endcase
      end
      PKT_DATA: begin
        case (index)
          3'd0:    sel = FldSourceID;
          3'd1:    sel = FldDestinationID;
          3'd2:    sel = FldSourceHops;
          3'd3:    sel = FldQValue;
          3'd4:    sel = FldEnergyLeft;
          default: sel = FldNone;
        endcase
      end
      PKT_CH_JOIN: begin
        case (index)
          3'd0:    sel = FldSourceID;
          3'd1:    sel = FldDestinationID;
          3'd2:    sel = FldChosenCH;
          3'd3:    sel = FldHopsFromCH;
          default: sel = FldNone;
        endcase
      end
      PKT_ROUTE_UPDATE: begin
        case (index)
          3'd0:    sel = FldSourceID;
          3'd1:    sel = FldEnergyLeft;
          3'd2:    sel = FldQValue;
          3'd3:    sel = FldSourceHops;
          3'd4:    sel = FldDestinationID;
          3'd5:    sel = FldChosenCH;
          3'd6:    sel = FldHopsFromCH;
          default: sel = FldNone;
        endcase
      end
      default: sel = FldNone;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/tx_payload_mux.sv
// Picks the snapshot field that forms payload word 'index' of a packet of type 'pktType'.
module tx_payload_mux #(
  parameter int unsigned WORD_WIDTH = tx_packet_builder_pkg::WORD_WIDTH
) (
  input  logic [2:0]                                 pktType,
  input  logic [tx_packet_builder_pkg::SelIdxW-1:0]  index,
  input  logic [WORD_WIDTH-1:0]                      sourceID,
  input  logic [WORD_WIDTH-1:0]                      energyLeft,
  input  logic [WORD_WIDTH-1:0]                      qValue,
  input  logic [WORD_WIDTH-1:0]                      sourceHops,
  input  logic [WORD_WIDTH-1:0]                      destinationID,
  input  logic [WORD_WIDTH-1:0]                      chosenCH,
  input  logic [WORD_WIDTH-1:0]                      hopsFromCH,
  output logic [WORD_WIDTH-1:0]                      word
);
  import tx_packet_builder_pkg::*;

  always_comb begin
    word = '0;
    case (fieldSel(pktType, index))
      FldSourceID:      word = sourceID;
      FldEnergyLeft:    word = energyLeft;
      FldQValue:        word = qValue;
      FldSourceHops:    word = sourceHops;
      FldDestinationID: word = destinationID;
      FldChosenCH:      word = chosenCH;
      FldHopsFromCH:    word = hopsFromCH;
      default:          word = '0;
    endcase
  end

endmodule

// File: rtl/tx_packet_builder.sv
// Snapshots the reward-stage outputs on start and streams header, payload and XOR
// checksum words to the radio TX buffer over valid/ready.
module tx_packet_builder #(
  parameter int unsigned WORD_WIDTH  = tx_packet_builder_pkg::WORD_WIDTH,
  parameter int unsigned MAX_PAYLOAD = 7
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] rSourceID,
  input  logic [WORD_WIDTH-1:0] rEnergyLeft,
  input  logic [WORD_WIDTH-1:0] rQValue,
  input  logic [WORD_WIDTH-1:0] rSourceHops,
  input  logic [WORD_WIDTH-1:0] rDestinationID,
  input  logic [2:0]            rPacketType,
  input  logic [WORD_WIDTH-1:0] rChosenCH,
  input  logic [WORD_WIDTH-1:0] rHopsFromCH,
  input  logic                  tx_ready,
  output logic [WORD_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  output logic                  tx_last,
  output logic                  busy,
  output logic                  tx_done,
  output logic                  err_type,
  output logic                  err_overrun
);
  import tx_packet_builder_pkg::*;

  localparam int unsigned IdxW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;

  typedef enum logic [2:0] {StIdle, StHeader, StPayload, StChecksum, StDone} stateE;

  stateE                 stateQ, stateD;
  logic [2:0]            typeQ;
  logic [WORD_WIDTH-1:0] sourceIDQ, energyLeftQ, qValueQ, sourceHopsQ;
  logic [WORD_WIDTH-1:0] destinationIDQ, chosenCHQ, hopsFromCHQ, checksumQ;
  logic [IdxW-1:0]       indexQ;
  logic                  errTypeQ, errOverrunQ;

  logic [3:0]            lenW;
  logic [SelIdxW-1:0]    muxIndex;
  logic [WORD_WIDTH-1:0] headerWord, payloadWord;
  logic                  accept, startPkt, lastPayload;

  assign lenW        = pktLen(typeQ);
  assign headerWord  = {typeQ, {(WORD_WIDTH - 7){1'b0}}, lenW};
  assign accept      = tx_valid && tx_ready;
  assign startPkt    = start && (stateQ == StIdle) && isValidType(rPacketType);
  assign lastPayload = (int'(indexQ) == int'(lenW) - 1);
  assign muxIndex    = SelIdxW'(indexQ);
  assign err_type    = errTypeQ;
  assign err_overrun = errOverrunQ;

  tx_payload_mux #(
    .WORD_WIDTH(WORD_WIDTH)
  ) uPayloadMux (
    .pktType      (typeQ),
    .index        (muxIndex),
    .sourceID     (sourceIDQ),
    .energyLeft   (energyLeftQ),
    .qValue       (qValueQ),
    .sourceHops   (sourceHopsQ),
    .destinationID(destinationIDQ),
    .chosenCH     (chosenCHQ),
    .hopsFromCH   (hopsFromCHQ),
    .word         (payloadWord)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      stateQ <= StIdle;
    end else begin
      stateQ <= stateD;
    end
  end

  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      StIdle:     if (startPkt) stateD = StHeader;
      StHeader:   if (tx_ready) stateD = StPayload;
      StPayload:  if (tx_ready && lastPayload) stateD = StChecksum;
      StChecksum: if (tx_ready) stateD = StDone;
      StDone:     stateD = StIdle;
      default:    stateD = StIdle;
    endcase
  end

  always_comb begin
    tx_valid = 1'b0;
    tx_last  = 1'b0;
    busy     = 1'b0;
    tx_done  = 1'b0;
    tx_data  = '0;
    unique case (stateQ)
      StHeader: begin
        tx_valid = 1'b1;
        busy     = 1'b1;
        tx_data  = headerWord;
      end
      StPayload: begin
        tx_valid = 1'b1;
        busy     = 1'b1;
        tx_data  = payloadWord;
      end
      StChecksum: begin
        tx_valid = 1'b1;
        tx_last  = 1'b1;
        busy     = 1'b1;
        tx_data  = checksumQ;
      end
      StDone:  tx_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      typeQ          <= '0;
      sourceIDQ      <= '0;
      energyLeftQ    <= '0;
      qValueQ        <= '0;
      sourceHopsQ    <= '0;
      destinationIDQ <= '0;
      chosenCHQ      <= '0;
      hopsFromCHQ    <= '0;
      checksumQ      <= '0;
      indexQ         <= '0;
      errTypeQ       <= 1'b0;
      errOverrunQ    <= 1'b0;
    end else begin
      errTypeQ    <= start && (stateQ == StIdle) && !isValidType(rPacketType);
      errOverrunQ <= start && (stateQ != StIdle);
      if (startPkt) begin
        typeQ          <= rPacketType;
        sourceIDQ      <= rSourceID;
        energyLeftQ    <= rEnergyLeft;
        qValueQ        <= rQValue;
        sourceHopsQ    <= rSourceHops;
        destinationIDQ <= rDestinationID;
        chosenCHQ      <= rChosenCH;
        hopsFromCHQ    <= rHopsFromCH;
        checksumQ      <= '0;
        indexQ         <= '0;
      end
      // The checksum word itself is not folded into the running XOR.
      if (accept && (stateQ != StChecksum)) begin
        checksumQ <= checksumQ ^ tx_data;
      end
      if (accept && (stateQ == StHeader)) begin
        indexQ <= '0;
      end else if (accept && (stateQ == StPayload)) begin
        indexQ <= indexQ + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tx_packet_builder.sv
// Randomised bench for tx_packet_builder, checked against a packet-level reference model.
module tb_tx_packet_builder;

  typedef struct packed {
    logic [15:0] srcId;
    logic [15:0] energy;
    logic [15:0] qVal;
    logic [15:0] srcHops;
    logic [15:0] destId;
    logic [15:0] chosenCh;
    logic [15:0] hopsCh;
  } fieldsT;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] rSourceID = '0, rEnergyLeft = '0, rQValue = '0, rSourceHops = '0;
  logic [15:0] rDestinationID = '0, rChosenCH = '0, rHopsFromCH = '0;
  logic [2:0]  rPacketType = '0;
  logic        tx_ready;
  logic [15:0] tx_data;
  logic        tx_valid, tx_last, busy, tx_done, err_type, err_overrun;

  tx_packet_builder #(
    .WORD_WIDTH (16),
    .MAX_PAYLOAD(7)
  ) dut (
    .clk           (clk),
    .nrst          (nrst),
    .start         (start),
    .rSourceID     (rSourceID),
    .rEnergyLeft   (rEnergyLeft),
    .rQValue       (rQValue),
    .rSourceHops   (rSourceHops),
    .rDestinationID(rDestinationID),
    .rPacketType   (rPacketType),
    .rChosenCH     (rChosenCH),
    .rHopsFromCH   (rHopsFromCH),
    .tx_ready      (tx_ready),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_last       (tx_last),
    .busy          (busy),
    .tx_done       (tx_done),
    .err_type      (err_type),
    .err_overrun   (err_overrun)
  );

  always #5 clk = ~clk;

  int nCompared = 0;
  int nMismatched = 0;
  int cyc = 0;
  int readyMode = 0;
  int readyPhase = 0;
  int doneCnt = 0;
  int errTypeCnt = 0;
  int errOverCnt = 0;

  logic [15:0] gotQ[$];
  logic        gotLastQ[$];
  int          gotCycQ[$];
  logic [15:0] expQ[$];

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // tx_ready: 0 = always high, 1 = repeating 1,0,0 pattern, 2 = random.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (readyMode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = (readyPhase % 3 == 0);
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
      readyPhase++;
    end
  end

  // Monitor: captures transfers and checks per-cycle handshake rules.
  initial begin
    logic        held;
    logic [15:0] heldData;
    held = 1'b0;
    heldData = '0;
    forever begin
      @(negedge clk);
      if (!nrst) begin
        held = 1'b0;
      end else begin
        if (held && tx_valid) checkVal("hold_stable", 32'(tx_data), 32'(heldData));
        if (tx_valid) checkVal("busy_with_valid", 32'(busy), 32'd1);
        if (tx_valid && tx_ready) begin
          gotQ.push_back(tx_data);
          gotLastQ.push_back(tx_last);
          gotCycQ.push_back(cyc);
        end
        if (tx_done) begin
          doneCnt++;
          checkVal("done_valid_low", 32'(tx_valid), 32'd0);
          checkVal("done_busy_low", 32'(busy), 32'd0);
        end
        errTypeCnt += int'(err_type);
        errOverCnt += int'(err_overrun);
        held = tx_valid && !tx_ready;
        heldData = tx_data;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic fieldsT randFields();
    fieldsT f;
    f.srcId    = 16'($urandom);
    f.energy   = 16'($urandom);
    f.qVal     = 16'($urandom);
    f.srcHops  = 16'($urandom);
    f.destId   = 16'($urandom);
    f.chosenCh = 16'($urandom);
    f.hopsCh   = 16'($urandom);
    return f;
  endfunction

  task automatic driveFields(input logic [2:0] t, input fieldsT f);
    rPacketType    = t;
    rSourceID      = f.srcId;
    rEnergyLeft    = f.energy;
    rQValue        = f.qVal;
    rSourceHops    = f.srcHops;
    rDestinationID = f.destId;
    rChosenCH      = f.chosenCh;
    rHopsFromCH    = f.hopsCh;
  endtask

  // Reference packet: header, type-ordered payload, XOR of all preceding words.
  task automatic buildExpected(input logic [2:0] t, input fieldsT f);
    logic [15:0] pl[$];
    logic [15:0] x;
    case (t)
      3'd1: begin
        pl.push_back(f.srcId); pl.push_back(f.srcHops); pl.push_back(f.qVal);
        pl.push_back(f.energy);
      end
      3'd2: begin
        pl.push_back(f.srcId); pl.push_back(f.srcHops); pl.push_back(f.qVal);
        pl.push_back(f.energy); pl.push_back(f.chosenCh);
      end
      3'd3: begin
        pl.push_back(f.srcId); pl.push_back(f.destId); pl.push_back(f.srcHops);
        pl.push_back(f.qVal); pl.push_back(f.energy);
      end
      3'd4: begin
        pl.push_back(f.srcId); pl.push_back(f.destId); pl.push_back(f.chosenCh);
        pl.push_back(f.hopsCh);
      end
      default: begin
        pl.push_back(f.srcId); pl.push_back(f.energy); pl.push_back(f.qVal);
        pl.push_back(f.srcHops); pl.push_back(f.destId); pl.push_back(f.chosenCh);
        pl.push_back(f.hopsCh);
      end
    endcase
    expQ.delete();
    expQ.push_back({t, 9'b0, 4'(pl.size())});
    foreach (pl[i]) expQ.push_back(pl[i]);
    x = '0;
    foreach (expQ[i]) x = x ^ expQ[i];
    expQ.push_back(x);
  endtask

  task automatic clearCapture();
    gotQ.delete();
    gotLastQ.delete();
    gotCycQ.delete();
  endtask

  task automatic pulseStart(input logic [2:0] t, input fieldsT f, output int sc);
    @(posedge clk);
    #1;
    driveFields(t, f);
    start = 1'b1;
    sc = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
    driveFields(3'($urandom), randFields());
  endtask

  task automatic finishPacket(input logic [2:0] t, input fieldsT f, input int sc,
                              input bit checkTiming);
    bit seen;
    int dc;
    buildExpected(t, f);
    seen = 1'b0;
    dc = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (tx_done) begin
        seen = 1'b1;
        dc = cyc;
      end
    end
    checkVal("done_seen", 32'(seen), 32'd1);
    checkVal("word_count", 32'(gotQ.size()), 32'(expQ.size()));
    for (int i = 0; i < expQ.size(); i++) begin
      if (i < gotQ.size()) begin
        checkVal($sformatf("word%0d_t%0d", i, t), 32'(gotQ[i]), 32'(expQ[i]));
        checkVal($sformatf("last%0d", i), 32'(gotLastQ[i]), 32'(i == expQ.size() - 1));
        if (checkTiming) checkVal($sformatf("word%0d_cycle", i), 32'(gotCycQ[i]), 32'(sc + 1 + i));
      end
    end
    if (checkTiming) checkVal("done_cycle", 32'(dc), 32'(sc + expQ.size() + 1));
  endtask

  task automatic runPacket(input logic [2:0] t, input fieldsT f, input bit checkTiming);
    int sc;
    clearCapture();
    pulseStart(t, f, sc);
    finishPacket(t, f, sc, checkTiming);
  endtask

  task automatic waitWords(input int n);
    for (int i = 0; i < 100 && gotQ.size() < n; i++) @(negedge clk);
    checkVal("reached_payload", 32'(gotQ.size() >= n), 32'd1);
  endtask

  initial begin
    fieldsT     f, g;
    int         sc, base;
    logic [2:0] badT[3];
    logic [2:0] t;

    // Reset state
    #12;
    checkVal("rst_valid", 32'(tx_valid), 32'd0);
    checkVal("rst_data", 32'(tx_data), 32'd0);
    checkVal("rst_busy", 32'(busy), 32'd0);
    checkVal("rst_last", 32'(tx_last), 32'd0);
    checkVal("rst_done", 32'(tx_done), 32'd0);
    checkVal("rst_errs", 32'({err_type, err_overrun}), 32'd0);
    @(negedge clk);
    #2;
    nrst = 1'b1;

    // Directed heartbeat, tx_ready high
    f = randFields();
    f.srcId = 16'h000c; f.srcHops = 16'h0001; f.qVal = 16'h0000; f.energy = 16'h8000;
    readyMode = 0;
    @(negedge clk);
    runPacket(3'd1, f, 1'b1);
    checkVal("hb_header", 32'(gotQ.size() > 0 ? gotQ[0] : 16'h0), 32'h2004);
    checkVal("hb_checksum", 32'(gotQ.size() > 5 ? gotQ[5] : 16'h0), 32'hA009);

    // Same heartbeat under 1,0,0 backpressure
    readyMode = 1;
    runPacket(3'd1, f, 1'b0);
    checkVal("bp_checksum", 32'(gotQ.size() > 5 ? gotQ[5] : 16'h0), 32'hA009);

    // Invalid types
    readyMode = 0;
    badT[0] = 3'd0; badT[1] = 3'd7; badT[2] = 3'd6;
    for (int i = 0; i < 3; i++) begin
      base = errTypeCnt;
      clearCapture();
      pulseStart(badT[i], randFields(), sc);
      @(negedge clk);
      checkVal("errtype_pulse", 32'(err_type), 32'd1);
      checkVal("errtype_no_valid", 32'(tx_valid), 32'd0);
      checkVal("errtype_no_busy", 32'(busy), 32'd0);
      repeat (3) @(negedge clk);
      checkVal("errtype_once", 32'(errTypeCnt - base), 32'd1);
      checkVal("errtype_no_words", 32'(gotQ.size()), 32'd0);
    end

    // Overrun: second start during DATA payload
    readyMode = 1;
    f = randFields();
    clearCapture();
    base = errOverCnt;
    pulseStart(3'd3, f, sc);
    waitWords(2);
    g = randFields();
    @(posedge clk);
    #1;
    driveFields(3'd1, g);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    checkVal("overrun_pulse", 32'(err_overrun), 32'd1);
    checkVal("overrun_no_errtype", 32'(err_type), 32'd0);
    finishPacket(3'd3, f, sc, 1'b0);
    checkVal("overrun_header", 32'(gotQ.size() > 0 ? gotQ[0] : 16'h0), 32'h6005);
    checkVal("overrun_count", 32'(errOverCnt - base), 32'd1);

    // Reset mid-packet
    readyMode = 1;
    f = randFields();
    clearCapture();
    pulseStart(3'd2, f, sc);
    waitWords(2);
    base = doneCnt;
    @(negedge clk);
    #2;
    nrst = 1'b0;
    #1;
    checkVal("midrst_valid", 32'(tx_valid), 32'd0);
    checkVal("midrst_data", 32'(tx_data), 32'd0);
    checkVal("midrst_busy", 32'(busy), 32'd0);
    checkVal("midrst_last", 32'(tx_last), 32'd0);
    checkVal("midrst_done", 32'(tx_done), 32'd0);
    @(negedge clk);
    #2;
    nrst = 1'b1;
    repeat (4) @(negedge clk);
    checkVal("midrst_no_done", 32'(doneCnt), 32'(base));
    readyMode = 0;
    runPacket(3'd2, randFields(), 1'b1);

    // Route update with distinct fields
    f.srcId = 16'h1111; f.energy = 16'h2222; f.qVal = 16'h3333; f.srcHops = 16'h4444;
    f.destId = 16'h5555; f.chosenCh = 16'h6666; f.hopsCh = 16'h7777;
    runPacket(3'd5, f, 1'b1);
    checkVal("ru_header", 32'(gotQ.size() > 0 ? gotQ[0] : 16'h0), 32'hA007);

    // Random back-to-back packets
    for (int n = 0; n < 30; n++) begin
      t = 3'($urandom_range(1, 5));
      readyMode = int'($urandom_range(0, 2));
      runPacket(t, randFields(), readyMode == 0);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/tx_packet_builder.md
Name: tx_packet_builder

Overview:
- Downstream of the reward stage.
- On the reward stage's reward_done pulse, snapshots the reward output fields (rSourceID, rEnergyLeft, rQValue, rSourceHops, rDestinationID, rPacketType, rChosenCH, rHopsFromCH).
- Serializes them into a header word, a type-dependent payload and an XOR checksum word.
- Streams the words over a valid/ready interface to the radio TX buffer.

Parameters:
- WORD_WIDTH, 16, width of every packet word and field.
- MAX_PAYLOAD, 7, maximum payload words; sizes the payload index counter.

Ports:
- clk  input  1  system clock, rising-edge.
- nrst  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; connect to reward_done.
- rSourceID  input  WORD_WIDTH  source node ID.
- rEnergyLeft  input  WORD_WIDTH  residual energy.
- rQValue  input  WORD_WIDTH  Q-value.
- rSourceHops  input  WORD_WIDTH  hops to sink.
- rDestinationID  input  WORD_WIDTH  destination node ID.
- rPacketType  input  3  packet type code.
- rChosenCH  input  WORD_WIDTH  chosen cluster head.
- rHopsFromCH  input  WORD_WIDTH  hops to cluster head.
- tx_ready  input  1  sink accepts the current word.
- tx_data  output  WORD_WIDTH  current word.
- tx_valid  output  1  tx_data valid.
- tx_last  output  1  current word is the checksum.
- busy  output  1  packet in progress.
- tx_done  output  1  one-cycle pulse after the checksum is accepted.
- err_type  output  1  one-cycle pulse, invalid type.
- err_overrun  output  1  one-cycle pulse, start while busy.

Behaviour:
- Reset:
  - Async; all outputs 0; FSM in IDLE; snapshot registers and checksum cleared.
  - Reset mid-packet aborts the packet; no tx_done is issued.
- FSM states: IDLE, HEADER, PAYLOAD, CHECKSUM, DONE.
- IDLE:
  - start with a valid type: latch all r* fields, go to HEADER, busy=1.
  - start with an invalid type (0, 6, 7): err_type pulses the next cycle; stay IDLE.
- Word timing:
  - HEADER: tx_valid=1 beginning the cycle after start.
  - A word transfers when tx_valid && tx_ready; tx_data is held stable until then.
  - HEADER to PAYLOAD when the header is accepted, index=0.
  - PAYLOAD: index increments per accepted word; move to CHECKSUM after word len-1.
  - CHECKSUM: tx_last=1; on accept go to DONE.
  - DONE: tx_done=1, busy=0, tx_valid=0 for one cycle, then IDLE.
- Header word: {rPacketType[2:0], 9'b0, len[3:0]}.
- Payload by type (fixed orders):
  - 1 HEARTBEAT: SourceID, SourceHops, QValue, EnergyLeft (len 4).
  - 2 CH_ANNOUNCE: SourceID, SourceHops, QValue, EnergyLeft, ChosenCH (len 5).
  - 3 DATA: SourceID, DestinationID, SourceHops, QValue, EnergyLeft (len 5).
  - 4 CH_JOIN: SourceID, DestinationID, ChosenCH, HopsFromCH (len 4).
  - 5 ROUTE_UPDATE: all seven fields in port order (len 7).
- Checksum: bitwise XOR of the header and all payload words, accumulated as each word is accepted.
- Overrun: start while busy (any state except IDLE) pulses err_overrun the next cycle. The current packet and snapshot are unaffected.
- Fixed timing:
  - Minimum packet duration with tx_ready tied high: len+2 cycles of tx_valid, plus the DONE cycle.
  - The cycle after DONE, IDLE accepts a new start; back-to-back packets leave exactly one idle tx_valid=0 cycle.
- Input fields may change freely after the start cycle; only the snapshot is used.

Decomposition:
- Shared package: packet type enum (PKT_HEARTBEAT=1, PKT_CH_ANNOUNCE=2, PKT_DATA=3, PKT_CH_JOIN=4, PKT_ROUTE_UPDATE=5), the type-to-length function, the payload field-select encoding, and WORD_WIDTH.
- One natural sub-module, tx_payload_mux: combinational selection of the snapshot field from type and index.

Test Plan:
- Heartbeat, tx_ready=1:
  - Stimulus: start with type 1, SourceID 000c, Hops 0001, Q 0000, Energy 8000.
  - Response: words 2004, 000c, 0001, 0000, 8000, A009 (tx_last on A009) on consecutive cycles, then one tx_done pulse.
- Backpressure:
  - Stimulus: same heartbeat, tx_ready toggling 1,0,0,1...
  - Response: each word held stable while tx_ready=0, no word lost or duplicated, same checksum A009.
- Invalid type:
  - Stimulus: start with type 0, then separately with type 7.
  - Response: err_type pulses once for each; tx_valid stays 0; busy stays 0.
- Overrun:
  - Stimulus: second start during the PAYLOAD of a DATA packet.
  - Response: err_overrun pulse; the emitted DATA packet matches the first snapshot (header 6005).
- Reset mid-packet:
  - Stimulus: nrst low during PAYLOAD.
  - Response: all outputs 0 immediately with no tx_done; the next valid start produces a correct full packet.
- Route update:
  - Stimulus: type 5 with distinct field values.
  - Response: header A007, 7 payload words in port order, checksum equals the XOR of all 8 words.
